// File: rtl/remote_load_formatter_if.sv
// Bundles the remote-load formatter's capture, memory and response signals.
// clk/reset stay outside the bundle as plain module ports.
interface remote_load_formatter_if #(
    parameter int data_width_p = 32
);
    logic                    capture_en_i;
    logic                    is_unsigned_op_i;
    logic                    is_byte_op_i;
    logic                    is_hex_op_i;
    logic [1:0]              part_sel_i;
    logic [data_width_p-1:0] mem_data_i;
    logic [data_width_p-1:0] load_data_o;
    logic                    load_v_o;
    logic [4:0]              info_o;

    // Request side plus memory: drives captures and the returned word.
    modport master (
        output capture_en_i, is_unsigned_op_i, is_byte_op_i, is_hex_op_i,
               part_sel_i, mem_data_i,
        input  load_data_o, load_v_o, info_o
    );

    // Formatter side.
    modport slave (
        input  capture_en_i, is_unsigned_op_i, is_byte_op_i, is_hex_op_i,
               part_sel_i, mem_data_i,
        output load_data_o, load_v_o, info_o
    );
endinterface

// File: rtl/remote_load_formatter.sv
// Response-side load formatter for remote loads. Captures the load attributes
// when a load is accepted; one cycle later the synchronous memory returns the
// full word and the selected byte/halfword/word is extracted and extended.
module remote_load_formatter #(
    parameter int         data_width_p     = 32,
    parameter logic [4:0] info_reset_val_p = 5'b0_0000
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    remote_load_formatter_if.slave  bus
);

    // Info packing: {is_unsigned, is_byte, is_hex, part_sel[1:0]}
    logic [4:0]              r_info_p0;
    logic                    r_vld_p0;
    logic [data_width_p-1:0] w_load_data;

    // Extract the addressed lane and sign- or zero-extend it. Byte beats
    // halfword when both flags are set; a word passes through untouched.
    function automatic logic [31:0] format_load(input logic [4:0]  info,
                                                input logic [31:0] word);
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        logic        ext_bit;
        logic [31:0] result;
        case (info[1:0])
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        // Halfword lane comes from part_sel[1] only; part_sel[0] is ignored.
        sel_half = info[1] ? word[31:16] : word[15:0];
        if (info[3]) begin
            ext_bit = ~info[4] & sel_byte[7];
            result  = {{24{ext_bit}}, sel_byte};
        end else if (info[2]) begin
            ext_bit = ~info[4] & sel_half[15];
            result  = {{16{ext_bit}}, sel_half};
        end else begin
            result  = word;
        end
        return result;
    endfunction

    // Capture stage: hold load info on accept; valid trails capture by one cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_info_p0 <= info_reset_val_p;
            r_vld_p0  <= 1'b0;
        end else begin
            r_vld_p0 <= bus.capture_en_i;
            if (bus.capture_en_i) begin
                r_info_p0 <= {bus.is_unsigned_op_i, bus.is_byte_op_i,
                              bus.is_hex_op_i, bus.part_sel_i};
            end
        end
    end

    // Format stage: combinational on registered info and the live memory word.
    always_comb begin
        w_load_data = format_load(r_info_p0, bus.mem_data_i);
    end

    assign bus.load_data_o = w_load_data;
    assign bus.load_v_o    = r_vld_p0;
    assign bus.info_o      = r_info_p0;

endmodule

// File: tb/tb_remote_load_formatter.sv
// Directed self-checking bench for remote_load_formatter.
module tb_remote_load_formatter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    remote_load_formatter_if #(.data_width_p(32)) bus ();

    remote_load_formatter #(
        .data_width_p    (32),
        .info_reset_val_p(5'b0_0000)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a capture, let one rising edge take it, then drop capture_en.
    task automatic do_capture(input logic u, input logic b, input logic h,
                              input logic [1:0] ps);
        bus.capture_en_i     = 1'b1;
        bus.is_unsigned_op_i = u;
        bus.is_byte_op_i     = b;
        bus.is_hex_op_i      = h;
        bus.part_sel_i       = ps;
        @(posedge clk);
        #1;
        bus.capture_en_i     = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.capture_en_i     = 1'b0;
        bus.is_unsigned_op_i = 1'b0;
        bus.is_byte_op_i     = 1'b0;
        bus.is_hex_op_i      = 1'b0;
        bus.part_sel_i       = 2'd0;
        bus.mem_data_i       = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.info_o !== 5'h00 || bus.load_v_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_init info=%h v=%b expected info=00 v=0", bus.info_o, bus.load_v_o);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Capture, then assert reset mid-cycle while the response is pending.
        do_capture(1'b1, 1'b1, 1'b0, 2'd3);
        checks++;
        if (bus.info_o !== 5'b11011 || bus.load_v_o !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_capture info=%h v=%b expected info=1b v=1", bus.info_o, bus.load_v_o);
        end
        bus.capture_en_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.info_o !== 5'h00 || bus.load_v_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset info=%h v=%b expected info=00 v=0", bus.info_o, bus.load_v_o);
        end
        // Capture held across an edge under reset must not register.
        @(posedge clk);
        #1;
        checks++;
        if (bus.info_o !== 5'h00 || bus.load_v_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority info=%h v=%b expected info=00 v=0", bus.info_o, bus.load_v_o);
        end
        bus.capture_en_i = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.load_v_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_valid v=%b expected 0", bus.load_v_o);
        end
    endtask

    task automatic test_byte;
        do_capture(1'b0, 1'b1, 1'b0, 2'd2);
        bus.mem_data_i = 32'h1280_3456;
        #1;
        checks++;
        if (bus.load_v_o !== 1'b1 || bus.info_o !== 5'b01010 || bus.load_data_o !== 32'hFFFF_FF80) begin
            failures++;
            $display("FAIL byte_signed v=%b info=%h data=%h expected v=1 info=0a data=ffffff80",
                     bus.load_v_o, bus.info_o, bus.load_data_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.load_v_o !== 1'b0) begin
            failures++;
            $display("FAIL byte_valid_single v=%b expected 0", bus.load_v_o);
        end
        do_capture(1'b1, 1'b1, 1'b0, 2'd2);
        #1;
        checks++;
        if (bus.load_v_o !== 1'b1 || bus.load_data_o !== 32'h0000_0080) begin
            failures++;
            $display("FAIL byte_unsigned v=%b data=%h expected v=1 data=00000080", bus.load_v_o, bus.load_data_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_halfword;
        do_capture(1'b0, 1'b0, 1'b1, 2'd3);
        bus.mem_data_i = 32'h8001_7FFF;
        #1;
        checks++;
        if (bus.load_v_o !== 1'b1 || bus.load_data_o !== 32'hFFFF_8001) begin
            failures++;
            $display("FAIL half_ps3 v=%b data=%h expected v=1 data=ffff8001", bus.load_v_o, bus.load_data_o);
        end
        @(posedge clk);
        #1;
        do_capture(1'b0, 1'b0, 1'b1, 2'd0);
        #1;
        checks++;
        if (bus.load_v_o !== 1'b1 || bus.load_data_o !== 32'h0000_7FFF) begin
            failures++;
            $display("FAIL half_ps0 v=%b data=%h expected v=1 data=00007fff", bus.load_v_o, bus.load_data_o);
        end
        @(posedge clk);
        #1;
        do_capture(1'b0, 1'b0, 1'b1, 2'd1);
        #1;
        checks++;
        if (bus.load_v_o !== 1'b1 || bus.load_data_o !== 32'h0000_7FFF) begin
            failures++;
            $display("FAIL half_ps1 v=%b data=%h expected v=1 data=00007fff", bus.load_v_o, bus.load_data_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_priority;
        do_capture(1'b1, 1'b0, 1'b0, 2'd3);
        bus.mem_data_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.load_v_o !== 1'b1 || bus.load_data_o !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL word v=%b data=%h expected v=1 data=deadbeef", bus.load_v_o, bus.load_data_o);
        end
        @(posedge clk);
        #1;
        do_capture(1'b1, 1'b1, 1'b1, 2'd1);
        bus.mem_data_i = 32'h0000_AB00;
        #1;
        checks++;
        if (bus.load_v_o !== 1'b1 || bus.load_data_o !== 32'h0000_00AB) begin
            failures++;
            $display("FAIL byte_priority v=%b data=%h expected v=1 data=000000ab", bus.load_v_o, bus.load_data_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        // First capture: signed byte, lane 0.
        bus.capture_en_i     = 1'b1;
        bus.is_unsigned_op_i = 1'b0;
        bus.is_byte_op_i     = 1'b1;
        bus.is_hex_op_i      = 1'b0;
        bus.part_sel_i       = 2'd0;
        @(posedge clk);
        #1;
        // Second capture presented immediately: signed word, lane 2.
        bus.is_byte_op_i = 1'b0;
        bus.part_sel_i   = 2'd2;
        bus.mem_data_i   = 32'h1122_33F4;
        #1;
        checks++;
        if (bus.load_v_o !== 1'b1 || bus.load_data_o !== 32'hFFFF_FFF4) begin
            failures++;
            $display("FAIL b2b_first v=%b data=%h expected v=1 data=fffffff4", bus.load_v_o, bus.load_data_o);
        end
        @(posedge clk);
        #1;
        bus.capture_en_i = 1'b0;
        bus.mem_data_i   = 32'hCAFE_F00D;
        #1;
        checks++;
        if (bus.load_v_o !== 1'b1 || bus.info_o !== 5'b00010 || bus.load_data_o !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL b2b_second v=%b info=%h data=%h expected v=1 info=02 data=cafef00d",
                     bus.load_v_o, bus.info_o, bus.load_data_o);
        end
        // Idle for three cycles: no valid, info persists.
        bus.is_unsigned_op_i = 1'b1;
        bus.is_byte_op_i     = 1'b1;
        bus.is_hex_op_i      = 1'b1;
        bus.part_sel_i       = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.load_v_o !== 1'b0 || bus.info_o !== 5'b00010) begin
                failures++;
                $display("FAIL hold_%0d v=%b info=%h expected v=0 info=02", i, bus.load_v_o, bus.info_o);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_byte();
        test_halfword();
        test_word_priority();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
